// File: rtl/riscorvo_mem_arbiter_if.sv
// Bundle of the fetch, data and downstream memory handshakes seen by riscorvo_mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface riscorvo_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned MW = DATA_WIDTH / 8;

    logic                  instr_valid_i;
    logic [ADDR_WIDTH-1:0] instr_addr_i;
    logic                  instr_ready_o;
    logic [DATA_WIDTH-1:0] instr_rdata_o;
    logic                  instr_err_o;

    logic                  data_valid_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic                  data_we_i;
    logic [MW-1:0]         data_mask_i;
    logic                  data_ready_o;
    logic [DATA_WIDTH-1:0] data_rdata_o;
    logic                  data_err_o;

    logic                  mem_valid_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_we_o;
    logic [MW-1:0]         mem_mask_o;
    logic                  mem_ready_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic [1:0]            grant_o;

    modport slave (
        input  instr_valid_i, instr_addr_i,
        output instr_ready_o, instr_rdata_o, instr_err_o,
        input  data_valid_i, data_addr_i, data_wdata_i, data_we_i, data_mask_i,
        output data_ready_o, data_rdata_o, data_err_o,
        output mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_mask_o,
        input  mem_ready_i, mem_rdata_i,
        output grant_o
    );

    modport master (
        output instr_valid_i, instr_addr_i,
        input  instr_ready_o, instr_rdata_o, instr_err_o,
        output data_valid_i, data_addr_i, data_wdata_i, data_we_i, data_mask_i,
        input  data_ready_o, data_rdata_o, data_err_o,
        input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_mask_o,
        output mem_ready_i, mem_rdata_i,
        input  grant_o
    );
endinterface

// File: rtl/riscorvo_mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one registered memory port, with
// back-to-back handoff to the other requester and a BUSY-state watchdog.
module riscorvo_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          DATA_PRIORITY  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    riscorvo_mem_arbiter_if.slave  bus
);
    localparam int unsigned MW = DATA_WIDTH / 8;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ABORT} state_e;

    state_e                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic [MW-1:0]         mem_mask_q, mem_mask_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW:0]           cnt_inc;

    logic                  launch_i, launch_d, handoff;
    logic                  instr_ready, instr_err, data_ready, data_err;
    logic [DATA_WIDTH-1:0] instr_rdata, data_rdata;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_mask_d  = mem_mask_q;
        cnt_d       = cnt_q;
        cnt_inc     = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
        launch_i    = 1'b0;
        launch_d    = 1'b0;
        handoff     = 1'b0;
        instr_ready = 1'b0;
        instr_err   = 1'b0;
        instr_rdata = '0;
        data_ready  = 1'b0;
        data_err    = 1'b0;
        data_rdata  = '0;

        case (state_q)
            IDLE: begin
                if (bus.data_valid_i && (DATA_PRIORITY || !bus.instr_valid_i)) launch_d = 1'b1;
                else if (bus.instr_valid_i)                                     launch_i = 1'b1;
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready_i) begin
                    if (state_q == BUSY_D) begin
                        data_ready = 1'b1;
                        data_rdata = bus.mem_rdata_i;
                    end else begin
                        instr_ready = 1'b1;
                        instr_rdata = bus.mem_rdata_i;
                    end
                    handoff = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_q != '1) cnt_d = cnt_inc[CW-1:0];
                    if (cnt_inc == LIMIT) begin
                        state_d     = ABORT;
                        mem_valid_d = 1'b0;
                    end
                end
            end
            ABORT: begin
                if (grant_q[1]) begin
                    data_ready = 1'b1;
                    data_err   = 1'b1;
                end else begin
                    instr_ready = 1'b1;
                    instr_err   = 1'b1;
                end
                handoff = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // The finishing side's valid still refers to the old transaction, so only the other side may be granted.
        if (handoff) begin
            if (grant_q[1] && bus.instr_valid_i)       launch_i = 1'b1;
            else if (grant_q[0] && bus.data_valid_i)   launch_d = 1'b1;
            else begin
                state_d     = IDLE;
                grant_d     = '0;
                mem_valid_d = 1'b0;
            end
        end

        if (launch_d) begin
            state_d     = BUSY_D;
            grant_d     = 2'b10;
            mem_valid_d = 1'b1;
            mem_addr_d  = bus.data_addr_i;
            mem_wdata_d = bus.data_wdata_i;
            mem_we_d    = bus.data_we_i;
            mem_mask_d  = bus.data_mask_i;
            cnt_d       = '0;
        end else if (launch_i) begin
            state_d     = BUSY_I;
            grant_d     = 2'b01;
            mem_valid_d = 1'b1;
            mem_addr_d  = bus.instr_addr_i;
            mem_wdata_d = '0;
            mem_we_d    = 1'b0;
            mem_mask_d  = '1;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_mask_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_mask_q  <= mem_mask_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.instr_ready_o = instr_ready;
    assign bus.instr_rdata_o = instr_rdata;
    assign bus.instr_err_o   = instr_err;
    assign bus.data_ready_o  = data_ready;
    assign bus.data_rdata_o  = data_rdata;
    assign bus.data_err_o    = data_err;
    assign bus.mem_valid_o   = mem_valid_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_wdata_o   = mem_wdata_q;
    assign bus.mem_we_o      = mem_we_q;
    assign bus.mem_mask_o    = mem_mask_q;
    assign bus.grant_o       = grant_q;
endmodule

// File: tb/tb_riscorvo_mem_arbiter.sv
// Directed bench for riscorvo_mem_arbiter: inputs driven on the falling edge,
// outputs checked 1 time unit later with immediate assertions.
module tb_riscorvo_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_i = 0;
    int   n_d = 0;

    riscorvo_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    riscorvo_mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16),
        .DATA_PRIORITY(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        bus.instr_valid_i = 1'b0;
        bus.instr_addr_i  = '0;
        bus.data_valid_i  = 1'b0;
        bus.data_addr_i   = '0;
        bus.data_wdata_i  = '0;
        bus.data_we_i     = 1'b0;
        bus.data_mask_i   = '0;
        bus.mem_ready_i   = 1'b0;
        bus.mem_rdata_i   = '0;

        // reset state
        cyc(); cyc(); #1;
        chk("rst_mem_valid", bus.mem_valid_o, 0);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        chk("rst_mem_mask", bus.mem_mask_o, 0);
        chk("rst_instr_ready", bus.instr_ready_o, 0);
        chk("rst_data_ready", bus.data_ready_o, 0);
        cyc(); rst = 1'b0;

        // 1: lone fetch, completion on the third BUSY cycle
        cyc();
        bus.instr_valid_i = 1'b1; bus.instr_addr_i = 32'h100; #1;
        chk("t1_no_grant_yet", bus.mem_valid_o, 0);
        cyc(); #1;
        chk("t1_mem_valid", bus.mem_valid_o, 1);
        chk("t1_grant", bus.grant_o, 2'b01);
        chk("t1_mem_addr", bus.mem_addr_o, 32'h100);
        chk("t1_mem_mask", bus.mem_mask_o, 4'hF);
        chk("t1_mem_we", bus.mem_we_o, 0);
        chk("t1_mem_wdata", bus.mem_wdata_o, 0);
        chk("t1_no_ready", bus.instr_ready_o, 0);
        cyc(); cyc();
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF; #1;
        chk("t1_instr_ready", bus.instr_ready_o, 1);
        chk("t1_instr_rdata", bus.instr_rdata_o, 32'hDEADBEEF);
        chk("t1_instr_err", bus.instr_err_o, 0);
        chk("t1_data_ready", bus.data_ready_o, 0);
        chk("t1_data_rdata", bus.data_rdata_o, 0);
        cyc();
        bus.instr_valid_i = 1'b0; #1;
        chk("t1_idle_valid", bus.mem_valid_o, 0);
        chk("t1_idle_grant", bus.grant_o, 0);
        chk("t1_idle_ready_ignored", bus.instr_ready_o, 0);
        chk("t1_idle_rdata", bus.instr_rdata_o, 0);
        bus.mem_ready_i = 1'b0;

        // 2: simultaneous fetch + store, data wins then fetch follows with no bubble
        cyc();
        bus.instr_valid_i = 1'b1; bus.instr_addr_i = 32'h200;
        bus.data_valid_i = 1'b1; bus.data_addr_i = 32'h2000; bus.data_wdata_i = 32'h12345678;
        bus.data_we_i = 1'b1; bus.data_mask_i = 4'h3;
        cyc(); #1;
        chk("t2_grant_d", bus.grant_o, 2'b10);
        chk("t2_addr_d", bus.mem_addr_o, 32'h2000);
        chk("t2_wdata_d", bus.mem_wdata_o, 32'h12345678);
        chk("t2_we_d", bus.mem_we_o, 1);
        chk("t2_mask_d", bus.mem_mask_o, 4'h3);
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hCAFE0001; #1;
        chk("t2_data_ready", bus.data_ready_o, 1);
        chk("t2_data_rdata", bus.data_rdata_o, 32'hCAFE0001);
        chk("t2_instr_quiet", bus.instr_ready_o, 0);
        cyc();
        bus.data_valid_i = 1'b0; bus.mem_ready_i = 1'b0; #1;
        chk("t2_grant_i", bus.grant_o, 2'b01);
        chk("t2_valid_i", bus.mem_valid_o, 1);
        chk("t2_addr_i", bus.mem_addr_o, 32'h200);
        chk("t2_mask_i", bus.mem_mask_o, 4'hF);
        chk("t2_we_i", bus.mem_we_o, 0);
        chk("t2_wdata_i", bus.mem_wdata_o, 0);
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'h11; #1;
        chk("t2_instr_ready", bus.instr_ready_o, 1);
        chk("t2_instr_rdata", bus.instr_rdata_o, 32'h11);
        chk("t2_data_rdata_zero", bus.data_rdata_o, 0);
        cyc();
        bus.instr_valid_i = 1'b0; bus.mem_ready_i = 1'b0; #1;
        chk("t2_idle", bus.grant_o, 0);

        // 3: continuous contention, ready every cycle -> strict alternation
        cyc();
        bus.instr_valid_i = 1'b1; bus.instr_addr_i = 32'h300;
        bus.data_valid_i = 1'b1; bus.data_addr_i = 32'h400;
        bus.data_we_i = 1'b0; bus.data_mask_i = 4'hF;
        cyc();
        for (int i = 0; i < 100; i++) begin
            bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'(i); #1;
            if (bus.data_ready_o === 1'b1) n_d++;
            if (bus.instr_ready_o === 1'b1) n_i++;
            if (i % 2 == 0) begin
                chk("t3_grant", bus.grant_o, 2'b10);
                chk("t3_addr", bus.mem_addr_o, 32'h400);
                chk("t3_data_ready", bus.data_ready_o, 1);
            end else begin
                chk("t3_grant", bus.grant_o, 2'b01);
                chk("t3_addr", bus.mem_addr_o, 32'h300);
                chk("t3_instr_ready", bus.instr_ready_o, 1);
            end
            cyc();
        end
        chk("t3_count_d", n_d, 50);
        chk("t3_count_i", n_i, 50);
        bus.instr_valid_i = 1'b0; bus.data_valid_i = 1'b0; #1;
        chk("t3_last_grant", bus.grant_o, 2'b10);
        cyc();
        bus.mem_ready_i = 1'b0; #1;
        chk("t3_idle", bus.grant_o, 0);

        // 4a: watchdog abort after 16 BUSY cycles without ready
        cyc();
        bus.data_valid_i = 1'b1; bus.data_addr_i = 32'h500;
        cyc();
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk("t4_busy_valid", bus.mem_valid_o, 1);
            chk("t4_busy_no_ready", bus.data_ready_o, 0);
            cyc();
        end
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hFFFF_FFFF; #1;
        chk("t4_abort_valid", bus.mem_valid_o, 0);
        chk("t4_abort_ready", bus.data_ready_o, 1);
        chk("t4_abort_err", bus.data_err_o, 1);
        chk("t4_abort_rdata", bus.data_rdata_o, 0);
        chk("t4_abort_grant", bus.grant_o, 2'b10);
        chk("t4_abort_instr_quiet", bus.instr_ready_o, 0);
        cyc();
        bus.data_valid_i = 1'b0; #1;
        chk("t4_after_idle", bus.grant_o, 0);
        chk("t4_idle_ignores_ready", bus.data_ready_o, 0);
        bus.mem_ready_i = 1'b0;

        // 4b: ready arrives on the 16th BUSY cycle -> normal completion wins
        cyc();
        bus.data_valid_i = 1'b1;
        cyc();
        for (int k = 1; k <= 15; k++) begin
            #1;
            chk("t4b_busy_valid", bus.mem_valid_o, 1);
            cyc();
        end
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hA5A5A5A5; #1;
        chk("t4b_ready", bus.data_ready_o, 1);
        chk("t4b_err", bus.data_err_o, 0);
        chk("t4b_rdata", bus.data_rdata_o, 32'hA5A5A5A5);
        cyc();
        bus.data_valid_i = 1'b0; bus.mem_ready_i = 1'b0; #1;
        chk("t4b_idle_valid", bus.mem_valid_o, 0);
        chk("t4b_idle_grant", bus.grant_o, 0);

        // 5: asynchronous reset during BUSY_D
        cyc();
        bus.data_valid_i = 1'b1; bus.data_addr_i = 32'h600;
        cyc(); #1;
        chk("t5_busy_grant", bus.grant_o, 2'b10);
        bus.mem_ready_i = 1'b1; #1;
        chk("t5_pre_reset_ready", bus.data_ready_o, 1);
        rst = 1'b1; #1;
        chk("t5_rst_ready", bus.data_ready_o, 0);
        chk("t5_rst_valid", bus.mem_valid_o, 0);
        chk("t5_rst_grant", bus.grant_o, 0);
        chk("t5_rst_addr", bus.mem_addr_o, 0);
        bus.mem_ready_i = 1'b0; bus.data_valid_i = 1'b0;
        cyc(); rst = 1'b0;
        cyc();
        bus.instr_valid_i = 1'b1; bus.instr_addr_i = 32'h700;
        cyc(); #1;
        chk("t5_fetch_grant", bus.grant_o, 2'b01);
        chk("t5_fetch_addr", bus.mem_addr_o, 32'h700);
        chk("t5_fetch_valid", bus.mem_valid_o, 1);
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'h77; #1;
        chk("t5_fetch_ready", bus.instr_ready_o, 1);
        cyc();
        bus.instr_valid_i = 1'b0; bus.mem_ready_i = 1'b0;

        // 6: upstream changes after grant do not disturb the latched request
        cyc();
        bus.data_valid_i = 1'b1; bus.data_addr_i = 32'h800; bus.data_wdata_i = 32'h55;
        bus.data_we_i = 1'b1; bus.data_mask_i = 4'h1;
        cyc(); #1;
        chk("t6_addr", bus.mem_addr_o, 32'h800);
        bus.data_addr_i = 32'h900; bus.data_wdata_i = 32'h66; bus.data_mask_i = 4'h2;
        cyc(); #1;
        chk("t6_addr_held", bus.mem_addr_o, 32'h800);
        chk("t6_wdata_held", bus.mem_wdata_o, 32'h55);
        chk("t6_mask_held", bus.mem_mask_o, 4'h1);
        cyc(); #1;
        chk("t6_addr_held2", bus.mem_addr_o, 32'h800);
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'h0; #1;
        chk("t6_ready", bus.data_ready_o, 1);
        cyc();
        bus.data_valid_i = 1'b0; bus.mem_ready_i = 1'b0; #1;
        chk("t6_idle", bus.grant_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
